// File: rtl/seq_multiplier_ctrl.sv
// ---------------------------------------------------------------------------
// seq_multiplier_ctrl
//
// Sequential shift-add multiplier with a start/busy/done handshake. Each
// cycle it retires BPC multiplier bits, so an operation takes WIDTH/BPC
// compute cycles plus one finishing cycle. Operands may be unsigned or two's
// complement, selected per operation. The magnitudes are multiplied, and the
// sign is applied once at the end. The product register holds the last
// completed result until the next operation completes.
//
// Parameters
//   WIDTH        operand width in bits (>= 4, divisible by BPC)
//   BPC          multiplier bits retired per cycle (1, 2 or 4)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   signed_mode  1 = operands are two's complement, 0 = unsigned
//   a            multiplicand, latched with start
//   b            multiplier, latched with start
//   abort        synchronous cancel; beats start while idle
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product becomes valid
//   product      2*WIDTH-bit result, held between completions
// ---------------------------------------------------------------------------
module seq_multiplier_ctrl #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW    = 2 * WIDTH;
   localparam int N     = WIDTH / BPC;
   localparam int CNT_W = $clog2(N) + 1;

   // Reject illegal configurations when the design is elaborated.
   generate
      if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
         $error("seq_multiplier_ctrl: BPC must be 1, 2 or 4");
      end
      if (WIDTH < 4 || (WIDTH % BPC) != 0) begin : g_bad_width
         $error("seq_multiplier_ctrl: WIDTH must be >= 4 and divisible by BPC");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   state_e             state_q, state_d;

   logic [PW-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [PW-1:0]      product_q, product_d;
   logic               done_q, done_d;

   // Control strobes decoded from the state.
   logic               accept;
   logic               step;
   logic               finish;
   logic               last_step;

   // Datapath helpers.
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [PW-1:0]      partial;

   assign last_step = (cnt_q == CNT_W'(N - 1));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking assignments only, so every
   // flop samples the values from before the edge regardless of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_step) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            // Abort or not, FIN always returns to IDLE; abort only
            // suppresses the result update below.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------
   always_comb begin
      busy   = 1'b0;
      accept = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state_q)
         S_IDLE: begin
            accept = start && !abort;
         end
         S_RUN: begin
            busy = 1'b1;
            step = !abort;
         end
         S_FIN: begin
            busy   = 1'b1;
            finish = !abort;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------

   // Magnitudes of the operands. The most negative value maps onto
   // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
   always_comb begin
      a_mag = a;
      b_mag = b;
      if (signed_mode && a[WIDTH-1]) begin
         a_mag = ~a + WIDTH'(1);
      end
      if (signed_mode && b[WIDTH-1]) begin
         b_mag = ~b + WIDTH'(1);
      end
   end

   // mcand * mplier[BPC-1:0] as a sum of shifted copies of mcand. mcand is
   // already aligned to the current bit position by the per-cycle shift.
   always_comb begin
      partial = '0;
      for (int j = 0; j < BPC; j++) begin
         if (mplier_q[j]) begin
            partial = partial + (mcand_q << j);
         end
      end
   end

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      done_d    = 1'b0;

      if (accept) begin
         mcand_d  = {{WIDTH{1'b0}}, a_mag};
         mplier_d = b_mag;
         neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step) begin
         acc_d    = acc_q + partial;
         mcand_d  = mcand_q << BPC;
         mplier_d = mplier_q >> BPC;
         cnt_d    = cnt_q + CNT_W'(1);
      end else if (finish) begin
         product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
         done_d    = 1'b1;
      end
   end

   // NOTE: the working registers are reset along with the control state.
   // This keeps the block free of X after reset even though an aborted or
   // reset operation never exposes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier_ctrl
//
// Bench for seq_multiplier_ctrl. It instantiates three 8-bit variants
// (BPC = 1, 2, 4 at index 0, 1, 2) and one 32-bit variant with BPC = 4.
// Expected products come from plain signed/unsigned multiplication, and
// expected latency is WIDTH/BPC + 1 cycles after the accept edge.
// Inputs are driven 1 time unit after a rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_seq_multiplier_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   // 8-bit instances, index k -> BPC = 1 << k
   logic        start8 [3];
   logic        sm8    [3];
   logic        abort8 [3];
   logic [7:0]  a8     [3];
   logic [7:0]  b8     [3];
   logic        busy8  [3];
   logic        done8  [3];
   logic [15:0] prod8  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut8
      seq_multiplier_ctrl #(.WIDTH(8), .BPC(1 << g)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start8[g]),
         .signed_mode (sm8[g]),
         .a           (a8[g]),
         .b           (b8[g]),
         .abort       (abort8[g]),
         .busy        (busy8[g]),
         .done        (done8[g]),
         .product     (prod8[g])
      );
   end

   // 32-bit instance, BPC = 4
   logic        start32, sm32, abort32;
   logic [31:0] a32, b32;
   logic        busy32, done32;
   logic [63:0] prod32;

   seq_multiplier_ctrl #(.WIDTH(32), .BPC(4)) u_dut32 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start32),
      .signed_mode (sm32),
      .a           (a32),
      .b           (b32),
      .abort       (abort32),
      .busy        (busy32),
      .done        (done32),
      .product     (prod32)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
      if (sm) return 16'($signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y}));
      return {8'h00, x} * {8'h00, y};
   endfunction

   function automatic logic [63:0] ref32(input logic sm, input logic [31:0] x, input logic [31:0] y);
      if (sm) return 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
      return {32'h0, x} * {32'h0, y};
   endfunction

   function automatic logic [7:0] pick8();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'h80;
         3:       return 8'h7F;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an operation for one edge (the accept edge), then scramble the
   // operand inputs. Returns 1 unit after the accept edge.
   task automatic start_op8(input int k, input logic sm, input logic [7:0] x, input logic [7:0] y);
      sm8[k]    = sm;
      a8[k]     = x;
      b8[k]     = y;
      start8[k] = 1'b1;
      step();
      start8[k] = 1'($urandom);
      sm8[k]    = 1'($urandom);
      a8[k]     = 8'($urandom);
      b8[k]     = 8'($urandom);
   endtask

   // Full operation on an 8-bit instance: busy/hold while running, exact
   // latency, product value, and a single-cycle done pulse.
   task automatic run_check8(input int k, input logic sm, input logic [7:0] x, input logic [7:0] y,
                             input logic [15:0] exp_p, input string name);
      int lat_exp;
      int lat;
      logic [15:0] old_p;
      lat_exp = (8 >> k) + 1;
      lat     = -1;
      old_p   = prod8[k];
      start_op8(k, sm, x, y);
      n_cmp++;
      if (busy8[k] !== 1'b1) begin
         n_bad++;
         $display("FAIL %s k=%0d busy_after_accept: got %b want 1", name, k, busy8[k]);
      end
      for (int c = 1; c <= lat_exp + 4; c++) begin
         step();
         if (done8[k] === 1'b1) begin
            start8[k] = 1'b0;
            lat = c;
            break;
         end
         start8[k] = (c < lat_exp) ? 1'($urandom) : 1'b0;
         n_cmp++;
         if (busy8[k] !== 1'b1 || prod8[k] !== old_p) begin
            n_bad++;
            $display("FAIL %s k=%0d running c=%0d: busy=%b product=%h want busy=1 product=%h",
                     name, k, c, busy8[k], prod8[k], old_p);
         end
      end
      start8[k] = 1'b0;
      n_cmp++;
      if (lat != lat_exp) begin
         n_bad++;
         $display("FAIL %s k=%0d latency: got %0d want %0d", name, k, lat, lat_exp);
      end
      n_cmp++;
      if (prod8[k] !== exp_p || busy8[k] !== 1'b0) begin
         n_bad++;
         $display("FAIL %s k=%0d result a=%h b=%h sm=%b: product=%h busy=%b want product=%h busy=0",
                  name, k, x, y, sm, prod8[k], busy8[k], exp_p);
      end
      step();
      n_cmp++;
      if (done8[k] !== 1'b0 || prod8[k] !== exp_p) begin
         n_bad++;
         $display("FAIL %s k=%0d after_done: done=%b product=%h want done=0 product=%h",
                  name, k, done8[k], prod8[k], exp_p);
      end
   endtask

   task automatic run_check32(input logic sm, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp_p);
      int lat;
      logic [63:0] old_p;
      lat   = -1;
      old_p = prod32;
      sm32 = sm; a32 = x; b32 = y; start32 = 1'b1;
      step();
      start32 = 1'($urandom); sm32 = 1'($urandom); a32 = $urandom; b32 = $urandom;
      for (int c = 1; c <= 13; c++) begin
         step();
         if (done32 === 1'b1) begin
            start32 = 1'b0;
            lat = c;
            break;
         end
         start32 = (c < 9) ? 1'($urandom) : 1'b0;
         if (busy32 !== 1'b1 || prod32 !== old_p) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand32 running c=%0d: busy=%b product=%h want busy=1 product=%h", c, busy32, prod32, old_p);
         end
      end
      start32 = 1'b0;
      n_cmp++;
      if (lat != 9) begin
         n_bad++;
         $display("FAIL rand32 latency: got %0d want 9", lat);
      end
      n_cmp++;
      if (prod32 !== exp_p) begin
         n_bad++;
         $display("FAIL rand32 product a=%h b=%h sm=%b: got %h want %h", x, y, sm, prod32, exp_p);
      end
      step();
      n_cmp++;
      if (done32 !== 1'b0 || busy32 !== 1'b0) begin
         n_bad++;
         $display("FAIL rand32 after_done: done=%b busy=%b want 0 0", done32, busy32);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (busy8[k] !== 1'b0 || done8[k] !== 1'b0 || prod8[k] !== 16'h0) begin
            n_bad++;
            $display("FAIL reset k=%0d: busy=%b done=%b product=%h want 0 0 0", k, busy8[k], done8[k], prod8[k]);
         end
      end
      n_cmp++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || prod32 !== 64'h0) begin
         n_bad++;
         $display("FAIL reset w32: busy=%b done=%b product=%h want 0 0 0", busy32, done32, prod32);
      end
   endtask

   task automatic test_unsigned_max();
      run_check8(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "unsigned_max");
   endtask

   task automatic test_signed();
      run_check8(1, 1'b1, 8'h80, 8'h80, 16'h4000, "signed_min_min");
      run_check8(1, 1'b1, 8'h80, 8'h7F, 16'hC080, "signed_min_max");
      run_check8(1, 1'b1, 8'hFF, 8'h01, 16'hFFFF, "signed_m1_p1");
      run_check8(1, 1'b0, 8'hFF, 8'h01, 16'h00FF, "unsigned_ff_01");
   endtask

   task automatic test_back_to_back();
      start_op8(0, 1'b0, 8'd3, 8'd5);
      start8[0] = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c < 9) begin
            n_cmp++;
            if (busy8[0] !== 1'b1 || done8[0] !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b first c=%0d: busy=%b done=%b want 1 0", c, busy8[0], done8[0]);
            end
         end
      end
      n_cmp++;
      if (done8[0] !== 1'b1 || busy8[0] !== 1'b0 || prod8[0] !== 16'h000F) begin
         n_bad++;
         $display("FAIL b2b first_done: done=%b busy=%b product=%h want 1 0 000f", done8[0], busy8[0], prod8[0]);
      end
      // Start again inside the done cycle.
      start_op8(0, 1'b0, 8'd7, 8'd9);
      start8[0] = 1'b0;
      n_cmp++;
      if (busy8[0] !== 1'b1 || done8[0] !== 1'b0 || prod8[0] !== 16'h000F) begin
         n_bad++;
         $display("FAIL b2b second_accept: busy=%b done=%b product=%h want 1 0 000f", busy8[0], done8[0], prod8[0]);
      end
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c < 9) begin
            n_cmp++;
            if (busy8[0] !== 1'b1 || done8[0] !== 1'b0 || prod8[0] !== 16'h000F) begin
               n_bad++;
               $display("FAIL b2b second c=%0d: busy=%b done=%b product=%h want 1 0 000f",
                        c, busy8[0], done8[0], prod8[0]);
            end
         end
      end
      n_cmp++;
      if (done8[0] !== 1'b1 || busy8[0] !== 1'b0 || prod8[0] !== 16'h003F) begin
         n_bad++;
         $display("FAIL b2b second_done: done=%b busy=%b product=%h want 1 0 003f", done8[0], busy8[0], prod8[0]);
      end
      step();
   endtask

   task automatic test_abort();
      run_check8(2, 1'b0, 8'hE9, 8'h14, 16'h1234, "abort_setup");
      // Abort during the second RUN cycle.
      start_op8(2, 1'b0, 8'h10, 8'h10);
      start8[2] = 1'b0;
      step();
      abort8[2] = 1'b1;
      step();
      abort8[2] = 1'b0;
      n_cmp++;
      if (busy8[2] !== 1'b0 || done8[2] !== 1'b0 || prod8[2] !== 16'h1234) begin
         n_bad++;
         $display("FAIL abort_run: busy=%b done=%b product=%h want 0 0 1234", busy8[2], done8[2], prod8[2]);
      end
      // Abort while in FIN.
      start_op8(2, 1'b0, 8'h10, 8'h10);
      start8[2] = 1'b0;
      step();
      step();
      abort8[2] = 1'b1;
      step();
      abort8[2] = 1'b0;
      n_cmp++;
      if (busy8[2] !== 1'b0 || done8[2] !== 1'b0 || prod8[2] !== 16'h1234) begin
         n_bad++;
         $display("FAIL abort_fin: busy=%b done=%b product=%h want 0 0 1234", busy8[2], done8[2], prod8[2]);
      end
      // start and abort together while idle: nothing is accepted.
      a8[2] = 8'h10; b8[2] = 8'h10; sm8[2] = 1'b0;
      start8[2] = 1'b1;
      abort8[2] = 1'b1;
      step();
      start8[2] = 1'b0;
      abort8[2] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (busy8[2] !== 1'b0 || done8[2] !== 1'b0 || prod8[2] !== 16'h1234) begin
            n_bad++;
            $display("FAIL start_abort_idle c=%0d: busy=%b done=%b product=%h want 0 0 1234",
                     c, busy8[2], done8[2], prod8[2]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_run();
      start_op8(1, 1'b0, 8'hFF, 8'hFF);
      start8[1] = 1'b0;
      step();
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (busy8[1] !== 1'b0 || done8[1] !== 1'b0 || prod8[1] !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_mid_run: busy=%b done=%b product=%h want 0 0 0", busy8[1], done8[1], prod8[1]);
      end
      #2;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         n_cmp++;
         if (busy8[1] !== 1'b0 || done8[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_resume c=%0d: busy=%b done=%b want 0 0", c, busy8[1], done8[1]);
         end
      end
      run_check8(1, 1'b0, 8'd2, 8'd3, 16'h0006, "after_reset");
   endtask

   task automatic test_random8();
      logic        sm;
      logic [7:0]  x, y;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 40; i++) begin
            sm = 1'($urandom);
            x  = pick8();
            y  = pick8();
            run_check8(k, sm, x, y, ref8(sm, x, y), "rand8");
         end
      end
   endtask

   task automatic test_random32();
      logic        sm;
      logic [31:0] x, y;
      for (int i = 0; i < 1000; i++) begin
         sm = 1'($urandom);
         x  = pick32();
         y  = pick32();
         run_check32(sm, x, y, ref32(sm, x, y));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         start8[k] = 1'b0; sm8[k] = 1'b0; abort8[k] = 1'b0; a8[k] = 8'h0; b8[k] = 8'h0;
      end
      start32 = 1'b0; sm32 = 1'b0; abort32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
      #2;
      rst_n = 1'b0;
      #1;
      test_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      test_reset();
      test_unsigned_max();
      test_signed();
      test_back_to_back();
      test_abort();
      test_reset_mid_run();
      test_random8();
      test_random32();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
